// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out shifter.
// No logic of its own; sizes the symbol counter for a given word depth.
// Backpressure behaviour is defined by the modules that import it.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter width for the remaining-symbol count, never narrower than one bit.
    function automatic int piso_cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Stream bundle for the shifter: one parallel word in, one symbol per beat out.
// Pure wiring, no latency.
// Valid/ready on both sides; the producer holds data while valid and not ready.
interface piso_shift_register_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*DEPTH-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/piso_ctrl.sv
// Control FSM and remaining-symbol counter for the serialiser (build option PISO_SHIFT_REGISTER_BACK_TO_BACK_EN).
// Registered out_valid/out_last appear one cycle after a word is accepted.
// in_ready drops while symbols are pending; with the option, it reopens on the last symbol if out_ready.
module piso_ctrl
    import piso_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic out_last,
    output logic load,
    output logic advance
);

    localparam int            CW       = piso_cnt_width(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
    localparam logic          ONE_SYM  = (DEPTH == 1);

    piso_state_t   state;
    logic [CW-1:0] count;
    logic          cnt_zero;

    assign cnt_zero = (count == '0);

`ifdef PISO_SHIFT_REGISTER_BACK_TO_BACK_EN
    // A new word may land in the same cycle the last symbol leaves.
    assign in_ready = (state == IDLE) | (out_ready & cnt_zero);
`else
    assign in_ready = (state == IDLE);
`endif

    assign load    = in_valid & in_ready;
    assign advance = out_valid & out_ready;

    // State, count and registered output flags; a reload at the last symbol keeps streaming.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        count     <= LAST_CNT;
                        out_valid <= 1'b1;
                        out_last  <= ONE_SYM;
                    end
                end
                SHIFT: begin
                    if (advance) begin
                        if (!cnt_zero) begin
                            count    <= count - CW'(1);
                            out_last <= (count == CW'(1));
                        end else if (load) begin
                            count    <= LAST_CNT;
                            out_last <= ONE_SYM;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter: WIDTH*DEPTH word out as DEPTH symbols, LSB symbol first (option PISO_SHIFT_REGISTER_BACK_TO_BACK_EN).
// First symbol one cycle after acceptance, one symbol per out_ready beat after that.
// out_data/out_last hold while stalled; input is refused until the word drains (or its last beat with the option).
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    piso_shift_register_if.slave bus
);

    localparam int WORD_W = WIDTH * DEPTH;

    logic [WORD_W-1:0] shreg;
    logic              load;
    logic              advance;

    piso_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .load      (load),
        .advance   (advance)
    );

    // Load wins over shift; shifting out the final symbol leaves zeros, so idle out_data reads 0.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= bus.in_data;
        end else if (advance) begin
            shreg <= shreg >> WIDTH;
        end
    end

    assign bus.out_data = shreg[WIDTH-1:0];

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for the serialiser: WIDTH=2/DEPTH=4 instance plus a DEPTH=1 instance.
// Inputs change and outputs are sampled on the falling edge.
// Back-to-back expectations follow PISO_SHIFT_REGISTER_BACK_TO_BACK_EN.
module tb_piso_shift_register;

    logic real_clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 real_clk = ~real_clk;

    piso_shift_register_if #(.WIDTH(2), .DEPTH(4)) bus ();
    piso_shift_register_if #(.WIDTH(2), .DEPTH(1)) bus1 ();

    piso_shift_register #(.WIDTH(2), .DEPTH(4)) u_dut (
        .CLK    (real_clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    piso_shift_register #(.WIDTH(2), .DEPTH(1)) u_dut1 (
        .CLK    (real_clk),
        .RESETN (rst_n),
        .bus    (bus1)
    );

    // Expected back-to-back stream, cycle i at bit i (data at [2i+:2]).
`ifdef PISO_SHIFT_REGISTER_BACK_TO_BACK_EN
    localparam int         B2B_CYC  = 8;
    localparam logic [8:0] B2B_VLD  = 9'b0_1111_1111;
    localparam logic [17:0] B2B_DAT = {2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [8:0] B2B_LST  = 9'b0_1000_1000;
    localparam logic       LAST_RDY = 1'b1;
`else
    localparam int         B2B_CYC  = 9;
    localparam logic [8:0] B2B_VLD  = 9'b1_1110_1111;
    localparam logic [17:0] B2B_DAT = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [8:0] B2B_LST  = 9'b1_0000_1000;
    localparam logic       LAST_RDY = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_sym(input string tag,
                              input logic got_v, input logic [1:0] got_d, input logic got_l,
                              input logic exp_v, input logic [1:0] exp_d, input logic exp_l);
        check($sformatf("%s_vld", tag), 32'(got_v), 32'(exp_v));
        check($sformatf("%s_dat", tag), 32'(got_d), 32'(exp_d));
        check($sformatf("%s_lst", tag), 32'(got_l), 32'(exp_l));
    endtask

    task automatic step();
        @(posedge real_clk);
        @(negedge real_clk);
    endtask

    initial begin
        logic [8:0]  vld_tab;
        logic [17:0] dat_tab;
        logic [8:0]  lst_tab;
        logic        drop;

        vld_tab = B2B_VLD;
        dat_tab = B2B_DAT;
        lst_tab = B2B_LST;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;

        // Reset state and the first cycle after release
        @(negedge real_clk);
        step();
        expect_sym("rst", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        expect_sym("post_rst", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        check("post_rst_rdy", 32'(bus.in_ready), 32'd1);

        // Single word 8'hE4, consumer always ready
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hE4;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        expect_sym("t1_s0", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd0, 1'b0);
        check("t1_s0_rdy", 32'(bus.in_ready), 32'd0);
        step();
        expect_sym("t1_s1", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd1, 1'b0);
        step();
        expect_sym("t1_s2", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd2, 1'b0);
        step();
        expect_sym("t1_s3", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd3, 1'b1);
        check("t1_s3_rdy", 32'(bus.in_ready), 32'(LAST_RDY));
        step();
        expect_sym("t1_idle", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        check("t1_idle_rdy", 32'(bus.in_ready), 32'd1);

        // Word 8'h1B with the consumer stalled on the first symbol
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h1B;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        expect_sym("t2_s0", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_sym($sformatf("t2_stall%0d", k), bus.out_valid, bus.out_data, bus.out_last,
                       1'b1, 2'd3, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        expect_sym("t2_s1", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd2, 1'b0);
        step();
        expect_sym("t2_s2", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd1, 1'b0);
        step();
        expect_sym("t2_s3", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd0, 1'b1);
        step();
        expect_sym("t2_idle", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);

        // Two words offered back to back: 8'hE4 then 8'h1B
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE4;
        step();
        bus.in_data = 8'h1B;
        for (int i = 0; i < B2B_CYC; i++) begin
            expect_sym($sformatf("t3_c%0d", i), bus.out_valid, bus.out_data, bus.out_last,
                       vld_tab[i], dat_tab[2*i +: 2], lst_tab[i]);
            drop = bus.in_valid & bus.in_ready;
            step();
            if (drop) bus.in_valid = 1'b0;
        end
        expect_sym("t3_idle", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        check("t3_in_valid_dropped", 32'(bus.in_valid), 32'd0);

        // Reset pulse mid-word discards the rest of 8'hE4
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE4;
        step();
        bus.in_valid = 1'b0;
        expect_sym("t4_s0", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd0, 1'b0);
        step();
        expect_sym("t4_s1", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd1, 1'b0);
        rst_n = 1'b0;
        step();
        expect_sym("t4_rst", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        check("t4_rst_rdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        expect_sym("t4_post", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        step();
        expect_sym("t4_no_resume", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h1B;
        step();
        bus.in_valid = 1'b0;
        expect_sym("t4_n0", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd3, 1'b0);
        step();
        expect_sym("t4_n1", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd2, 1'b0);
        step();
        expect_sym("t4_n2", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd1, 1'b0);
        step();
        expect_sym("t4_n3", bus.out_valid, bus.out_data, bus.out_last, 1'b1, 2'd0, 1'b1);
        step();
        expect_sym("t4_idle", bus.out_valid, bus.out_data, bus.out_last, 1'b0, 2'd0, 1'b0);

        // DEPTH=1 instance: one symbol per word, always last
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 2'h2;
        bus1.out_ready = 1'b1;
        check("d1_rdy", 32'(bus1.in_ready), 32'd1);
        step();
        bus1.in_valid = 1'b0;
        expect_sym("d1_s0", bus1.out_valid, bus1.out_data, bus1.out_last, 1'b1, 2'd2, 1'b1);
        step();
        expect_sym("d1_idle", bus1.out_valid, bus1.out_data, bus1.out_last, 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the bit width of one output symbol.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the symbols per loaded word (legal range >= 1).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the parallel word is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH*DEPTH bits: the parallel word; symbol k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port out_valid, output, 1 bit: a serial symbol is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the symbol.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the current symbol.
REQ-011 The block SHALL have port out_last, output, 1 bit: the current symbol is symbol DEPTH-1 of its word.

Function
REQ-012 The block SHALL implement two states: IDLE (empty) and SHIFT (symbols pending).
REQ-013 In IDLE: in_ready=1, out_valid=0, out_last=0, out_data=0.
REQ-014 On an input handshake (in_valid & in_ready): load in_data into the shift register, set the remaining-count to DEPTH-1, and enter SHIFT; out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-015 In SHIFT: out_valid=1, out_data=shift register bits [WIDTH-1:0], and out_last=1 exactly when the remaining-count is 0.
REQ-016 On an output handshake (out_valid & out_ready) with count>0: shift right by WIDTH with zero fill and decrement count.
REQ-017 Symbols SHALL be emitted in order 0,1,...,DEPTH-1 (LSB symbol first).
REQ-018 While out_valid=1 and out_ready=0: out_data, out_last and the state SHALL hold unchanged.
REQ-019 On an output handshake with count=0 and no simultaneous load: return to IDLE.
REQ-020 For DEPTH=1, every word SHALL produce one symbol with out_last=1.
REQ-021 The count register SHALL be max(1,$clog2(DEPTH)) bits wide; it never wraps below 0.

Reset
REQ-022 When RESETN=0 at a rising CLK: state=IDLE, shift register=0, count=0; any partially shifted word SHALL be discarded with no further symbols emitted.
REQ-023 During reset and on the first cycle after it: out_valid=0, out_last=0, out_data=0, in_ready=1.

Configuration
REQ-024 The macro PISO_SHIFT_REGISTER_BACK_TO_BACK_EN SHALL select zero-bubble reload.
REQ-025 With the macro defined: in SHIFT, in_ready=out_ready & (count==0); a simultaneous last-symbol output handshake and input handshake SHALL load the new word and stay in SHIFT, giving continuous out_valid.
REQ-026 Without the macro: in_ready=0 throughout SHIFT, and exactly one IDLE cycle separates consecutive words.

Structure
REQ-027 The shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the count-width function.
REQ-028 The FSM and counter SHALL be in sub-module piso_ctrl; the shift-register datapath SHALL stay in the top level.

Verification (WIDTH=2, DEPTH=4)
REQ-029 Reset, then in_data=8'hE4 accepted with out_ready=1 -> out_data 0,1,2,3 on four consecutive cycles from the cycle after acceptance, out_last only on the 3; then IDLE.
REQ-030 Word 8'h1B with out_ready deasserted for 3 cycles after the first symbol -> out_data holds 3 and out_last holds 0 while stalled; the sequence then resumes 2,1,0.
REQ-031 Two words 8'hE4 then 8'h1B offered back-to-back with out_ready=1 -> with the macro: 8 consecutive out_valid cycles 0,1,2,3,3,2,1,0. Without the macro: one out_valid=0 gap between the words.
REQ-032 RESETN pulsed low after the second symbol of 8'hE4 -> out_valid=0 the following cycle; the remaining symbols 2,3 are never emitted; the next word 8'h1B streams 3,2,1,0 cleanly.
REQ-033 DEPTH=1 build, in_data=2'h2 -> a single symbol 2 with out_last=1, then IDLE.
